register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; depth SHALL be 2**ADDR_W.
REQ-003 Parameter NRD, default 2, number of read ports, range 1..4.
REQ-004 Parameter BYPASS, default 1: 1 = write-to-read forwarding in the same cycle, 0 = none.
REQ-005 Parameter ZERO_REG, default 1: 1 = register 0 reads 0 and ignores writes.
REQ-006 clock  in  1  sole clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 rd_addr  in  NRD*ADDR_W  read addresses; port i is at bits [i*ADDR_W +: ADDR_W].
REQ-009 rd_data  out  NRD*DATA_W  read data, packed the same way.
REQ-010 rd_busy  out  NRD  scoreboard bit of the register addressed by each read port.
REQ-011 wa_en, wa_addr, wa_data, wa_be  in  1/ADDR_W/DATA_W/DATA_W/8  write port A (ALU writeback).
REQ-012 wb_en, wb_addr, wb_data, wb_be  in  1/ADDR_W/DATA_W/DATA_W/8  write port B (load return).
REQ-013 sb_set_en, sb_set_addr  in  1/ADDR_W  marks a register busy (load issued).

Function
REQ-014 Reads SHALL be combinational: rd_data[i] = reg[rd_addr[i]], with zero clock latency.
REQ-015 On each rising edge, a write port whose enable is high SHALL update only the bytes whose be bit is set; the other bytes keep their value.
REQ-016 When port A and port B write the same address in one cycle, the bytes enabled on B SHALL take B's data. Bytes enabled only on A SHALL take A's data.
REQ-017 When ZERO_REG=1, writes to address 0 SHALL be discarded, register 0 SHALL read 0 on every port, and rd_busy for address 0 SHALL be 0.
REQ-018 When BYPASS=1, if rd_addr[i] equals an enabled write address, rd_data[i] SHALL equal the post-edge value: stored bytes merged with A's bytes, then B's bytes, per REQ-016.
REQ-019 When BYPASS=0, rd_data SHALL show the stored value until the edge; the new value appears in the cycle after the write.
REQ-020 Scoreboard: one bit per register. sb_set_en sets bit[sb_set_addr] at the edge. wb_en clears bit[wb_addr] at the edge, whatever wb_be is.
REQ-021 If a set and a clear hit the same register in one cycle, the set SHALL win and the bit SHALL end at 1.
REQ-022 rd_busy[i] SHALL be combinational from the current scoreboard and SHALL NOT be bypassed by a same-cycle set or clear.
REQ-023 Writes on port A SHALL NOT change the scoreboard.
REQ-024 Address wrap: every ADDR_W value is a valid index; there SHALL be no out-of-range case.

Reset
REQ-025 While reset is high, all registers SHALL be 0 and all scoreboard bits SHALL be 0. As a result, rd_data = 0 and rd_busy = 0 on every port.
REQ-026 Reset SHALL take effect with no clock edge. Writes and sets presented while reset is high SHALL be ignored.
REQ-027 When reset is asserted in the middle of operation, pending busy bits SHALL be lost.
REQ-028 After reset deasserts, the first rising edge SHALL process writes normally.

Structure
REQ-029 A shared package SHALL hold the default DATA_W and ADDR_W, plus the function that merges by byte enable (used by the write path and the bypass path).
REQ-030 One sub-module, regfile_scoreboard, SHALL contain the busy-bit array and its set/clear priority. The storage and read muxes stay in register_file_mp.

Verification
REQ-031 Reset pulse, then port A writes 0x00000233 to reg 7 with be=0xF, rd_addr[1]=7 -> with BYPASS=1, rd_data[1]=0x233 in the same cycle; with BYPASS=0, it appears the next cycle.
REQ-032 Reg 3=0x11223344; port A writes 0xAABBCCDD be=0x3 -> reg 3 reads 0x1122CCDD.
REQ-033 Same cycle: A writes reg 5=0xFFFFFFFF be=0xF and B writes reg 5=0x00000000 be=0x1 -> reg 5 reads 0xFFFFFF00.
REQ-034 ZERO_REG=1: write 0xDEADBEEF to reg 0 on both ports -> every read port at address 0 returns 0.
REQ-035 sb_set reg 9 -> rd_busy=1 the next cycle. B writes reg 9 -> busy=0 the next cycle. sb_set and wb on reg 9 in the same cycle -> busy stays 1.
REQ-036 Write reg 4=0x55, set busy on reg 4, assert reset between edges -> reg 4 reads 0 and rd_busy=0 immediately, before any edge.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared defaults and the byte-enable merge used by the register write path and
// the read bypass path.
package register_file_mp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // One byte of the post-edge value: the load-return port overrides the ALU port.
  function automatic logic [7:0] merge_byte(
    input logic [7:0] old_b,
    input logic [7:0] a_b,
    input logic       a_en,
    input logic [7:0] b_b,
    input logic       b_en
  );
    if (b_en) return b_b;
    if (a_en) return a_b;
    return old_b;
  endfunction
endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Busy-bit array: one bit per register, set when a load issues and cleared when
// its data returns on write port B. A same-cycle set beats the clear.
module regfile_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_set_en,
  input  logic [ADDR_W-1:0]     i_set_addr,
  input  logic                  i_clr_en,
  input  logic [ADDR_W-1:0]     i_clr_addr,
  input  logic [NRD*ADDR_W-1:0] i_rd_addr,
  output logic [NRD-1:0]        o_rd_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_busy;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= '0;
    end else begin
      if (i_clr_en) r_busy[i_clr_addr] <= 1'b0;
      if (i_set_en) r_busy[i_set_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_busy
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = i_rd_addr[g*ADDR_W +: ADDR_W];
    assign o_rd_busy[g] = (ZERO_REG != 0 && w_ra == '0) ? 1'b0 : r_busy[w_ra];
  end
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NRD combinational read ports, two byte-enabled write
// ports (B has priority on shared bytes), optional forwarding and hard-wired r0.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NRD*ADDR_W-1:0] i_rd_addr,
  output logic [NRD*DATA_W-1:0] o_rd_data,
  output logic [NRD-1:0]        o_rd_busy,
  input  logic                  i_wa_en,
  input  logic [ADDR_W-1:0]     i_wa_addr,
  input  logic [DATA_W-1:0]     i_wa_data,
  input  logic [DATA_W/8-1:0]   i_wa_be,
  input  logic                  i_wb_en,
  input  logic [ADDR_W-1:0]     i_wb_addr,
  input  logic [DATA_W-1:0]     i_wb_data,
  input  logic [DATA_W/8-1:0]   i_wb_be,
  input  logic                  i_sb_set_en,
  input  logic [ADDR_W-1:0]     i_sb_set_addr
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_a_hit;
  logic [DEPTH-1:0]  w_b_hit;

  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] cur,
    input logic              a_hit,
    input logic [DATA_W-1:0] a_data,
    input logic [NB-1:0]     a_be,
    input logic              b_hit,
    input logic [DATA_W-1:0] b_data,
    input logic [NB-1:0]     b_be
  );
    logic [DATA_W-1:0] res;
    for (int k = 0; k < NB; k++) begin
      res[k*8 +: 8] = merge_byte(cur[k*8 +: 8],
                                 a_data[k*8 +: 8], a_hit & a_be[k],
                                 b_data[k*8 +: 8], b_hit & b_be[k]);
    end
    return res;
  endfunction

  always_comb begin
    w_a_hit = '0;
    w_b_hit = '0;
    if (i_wa_en) w_a_hit[i_wa_addr] = 1'b1;
    if (i_wb_en) w_b_hit[i_wb_addr] = 1'b1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((ZERO_REG == 0 || j != 0) && (w_a_hit[j] || w_b_hit[j])) begin
          r_mem[j] <= merge_word(r_mem[j], w_a_hit[j], i_wa_data, i_wa_be,
                                 w_b_hit[j], i_wb_data, i_wb_be);
        end
      end
    end
  end

  // Forwarding is masked during reset so reads stay at zero while writes are ignored.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_ah;
    logic              w_bh;
    logic [DATA_W-1:0] w_rv;
    assign w_ra = i_rd_addr[g*ADDR_W +: ADDR_W];
    assign w_ah = (BYPASS != 0) && !i_reset && i_wa_en && (i_wa_addr == w_ra);
    assign w_bh = (BYPASS != 0) && !i_reset && i_wb_en && (i_wb_addr == w_ra);
    assign w_rv = merge_word(r_mem[w_ra], w_ah, i_wa_data, i_wa_be,
                             w_bh, i_wb_data, i_wb_be);
    assign o_rd_data[g*DATA_W +: DATA_W] = (ZERO_REG != 0 && w_ra == '0) ? '0 : w_rv;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NRD     (NRD),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_set_en  (i_sb_set_en),
    .i_set_addr(i_sb_set_addr),
    .i_clr_en  (i_wb_en),
    .i_clr_addr(i_wb_addr),
    .i_rd_addr (i_rd_addr),
    .o_rd_busy (o_rd_busy)
  );
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a forwarding instance and a non-forwarding instance
// share stimulus; directed table, mid-operation reset, then random traffic.
module tb_register_file_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_byp, rd_nob;
  logic [1:0]  busy_byp, busy_nob;
  logic        wa_en, wb_en, sb_en;
  logic [4:0]  wa_addr, wb_addr, sb_addr;
  logic [31:0] wa_data, wb_data;
  logic [3:0]  wa_be, wb_be;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut_byp (
    .i_clock(clk), .i_reset(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_byp), .o_rd_busy(busy_byp),
    .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data), .i_wa_be(wa_be),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_be(wb_be),
    .i_sb_set_en(sb_en), .i_sb_set_addr(sb_addr));

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_nob (
    .i_clock(clk), .i_reset(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_nob), .o_rd_busy(busy_nob),
    .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data), .i_wa_be(wa_be),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_be(wb_be),
    .i_sb_set_en(sb_en), .i_sb_set_addr(sb_addr));

  typedef struct {
    logic [4:0]  ra0, ra1;
    logic        wa_en;  logic [4:0] wa_addr; logic [31:0] wa_data; logic [3:0] wa_be;
    logic        wb_en;  logic [4:0] wb_addr; logic [31:0] wb_data; logic [3:0] wb_be;
    logic        sb_en;  logic [4:0] sb_addr;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic ae, input logic [4:0] aa, input logic [31:0] ad, input logic [3:0] ab,
    input logic be_, input logic [4:0] ba, input logic [31:0] bd, input logic [3:0] bb,
    input logic se, input logic [4:0] sa,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1;
    v.wa_en = ae; v.wa_addr = aa; v.wa_data = ad; v.wa_be = ab;
    v.wb_en = be_; v.wb_addr = ba; v.wb_data = bd; v.wb_be = bb;
    v.sb_en = se; v.sb_addr = sa;
    v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    wa_en = 1'b0; wa_addr = '0; wa_data = '0; wa_be = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_be = '0;
    sb_en = 1'b0; sb_addr = '0;
  endtask

  // Value register a holds after the coming edge: A's bytes first, then B's on top.
  function automatic logic [31:0] post_val(input logic [4:0] a);
    logic [31:0] v;
    v = m_mem[a];
    for (int k = 0; k < 4; k++)
      if (wa_en && wa_addr == a && wa_be[k]) v[k*8 +: 8] = wa_data[k*8 +: 8];
    for (int k = 0; k < 4; k++)
      if (wb_en && wb_addr == a && wb_be[k]) v[k*8 +: 8] = wb_data[k*8 +: 8];
    if (a == 5'd0) v = '0;
    return v;
  endfunction

  function automatic logic [31:0] stored(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return (a == 5'd0) ? 1'b0 : m_busy[a];
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 32; j++) begin
      m_mem[j] = '0;
      m_busy[j] = 1'b0;
    end
  endtask

  task automatic model_commit();
    logic [31:0] na, nb;
    na = post_val(wa_addr);
    nb = post_val(wb_addr);
    if (wa_en) m_mem[wa_addr] = na;
    if (wb_en) m_mem[wb_addr] = nb;
    if (wb_en) m_busy[wb_addr] = 1'b0;
    if (sb_en) m_busy[sb_addr] = 1'b1;
  endtask

  task automatic chk_model();
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a;
      a = rd_addr[p*5 +: 5];
      chk("byp_rd", rd_byp[p*32 +: 32], post_val(a));
      chk("nob_rd", rd_nob[p*32 +: 32], stored(a));
      chk("byp_busy", {31'b0, busy_byp[p]}, {31'b0, exp_busy(a)});
      chk("nob_busy", {31'b0, busy_nob[p]}, {31'b0, exp_busy(a)});
    end
  endtask

  // Inputs are already driven; check mid-cycle, then let the edge happen.
  task automatic step();
    @(negedge clk);
    chk_model();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rd_addr = {5'd7, 5'd3};
    drive_idle();
    model_reset();

    // Reset state, including a write presented while reset is held.
    #3;
    chk("rst_rd", rd_byp[63:32] | rd_byp[31:0], 32'h0);
    chk("rst_busy", {30'b0, busy_byp | busy_nob}, 32'h0);
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'hFFFF_FFFF; wa_be = 4'hF;
    #1;
    chk("rst_byp_wr", rd_byp[63:32], 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_edge_rd", rd_nob[63:32], 32'h0);
    drive_idle();
    rst = 1'b0;

    tbl.push_back(mk(0, 7, 1, 7, 32'h0000_0233, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0, 32'h233, 2'b00));
    tbl.push_back(mk(7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h233, 32'h0, 2'b00));
    tbl.push_back(mk(3, 7, 1, 3, 32'h1122_3344, 4'hF, 0, 0, 0, 0, 0, 0, 32'h1122_3344, 32'h233, 2'b00));
    tbl.push_back(mk(3, 3, 1, 3, 32'hAABB_CCDD, 4'h3, 0, 0, 0, 0, 0, 0, 32'h1122_CCDD, 32'h1122_CCDD, 2'b00));
    tbl.push_back(mk(3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1122_CCDD, 32'h233, 2'b00));
    tbl.push_back(mk(5, 5, 1, 5, 32'hFFFF_FFFF, 4'hF, 1, 5, 32'h0, 4'h1, 0, 0, 32'hFFFF_FF00, 32'hFFFF_FF00, 2'b00));
    tbl.push_back(mk(5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FF00, 32'h1122_CCDD, 2'b00));
    tbl.push_back(mk(0, 0, 1, 0, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 32'h0, 2'b00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00));
    tbl.push_back(mk(9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h0, 32'h0, 2'b00));
    tbl.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b01));
    tbl.push_back(mk(9, 9, 0, 0, 0, 0, 1, 9, 32'h1234_5678, 4'hF, 0, 0, 32'h1234_5678, 32'h1234_5678, 2'b11));
    tbl.push_back(mk(9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 2'b00));
    tbl.push_back(mk(9, 9, 0, 0, 0, 0, 1, 9, 32'hCAFE_F00D, 4'h0, 1, 9, 32'h1234_5678, 32'h1234_5678, 2'b00));
    tbl.push_back(mk(9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 2'b11));
    tbl.push_back(mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h1234_5678, 2'b10));
    tbl.push_back(mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h1234_5678, 2'b10));

    for (int i = 0; i < tbl.size(); i++) begin
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      wa_en = tbl[i].wa_en; wa_addr = tbl[i].wa_addr; wa_data = tbl[i].wa_data; wa_be = tbl[i].wa_be;
      wb_en = tbl[i].wb_en; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data; wb_be = tbl[i].wb_be;
      sb_en = tbl[i].sb_en; sb_addr = tbl[i].sb_addr;
      @(negedge clk);
      chk($sformatf("tbl%0d_rd0", i), rd_byp[31:0], tbl[i].e0);
      chk($sformatf("tbl%0d_rd1", i), rd_byp[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d_busy", i), {30'b0, busy_byp}, {30'b0, tbl[i].eb});
      chk_model();
      @(posedge clk);
      model_commit();
      #1;
    end

    // Reset between edges wipes data and busy bits at once.
    rd_addr = {5'd4, 5'd4};
    drive_idle();
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h55; wa_be = 4'hF;
    sb_en = 1'b1; sb_addr = 5'd4;
    step();
    drive_idle();
    #1;
    chk("pre_rst_rd", rd_nob[31:0], 32'h55);
    chk("pre_rst_busy", {30'b0, busy_nob}, 32'h3);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_byp", rd_byp[31:0], 32'h0);
    chk("mid_rst_rd_nob", rd_nob[63:32], 32'h0);
    chk("mid_rst_busy", {30'b0, busy_byp | busy_nob}, 32'h0);
    model_reset();
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h0000_00FF; wa_be = 4'hF;
    sb_en = 1'b1; sb_addr = 5'd4;
    #1;
    chk("rst_byp_mask", rd_byp[31:0], 32'h0);
    @(posedge clk); #1;
    chk("rst_wr_ign", rd_nob[31:0], 32'h0);
    chk("rst_set_ign", {30'b0, busy_nob}, 32'h0);
    rst = 1'b0;
    step();
    drive_idle();
    step();

    // Random traffic, addresses biased to a small window to force collisions.
    for (int c = 0; c < 500; c++) begin
      logic [4:0] r0, r1;
      wa_en = 1'($urandom_range(0, 1));
      wb_en = 1'($urandom_range(0, 2) == 0);
      sb_en = 1'($urandom_range(0, 2) == 0);
      wa_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wb_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      sb_addr = 5'($urandom_range(0, 7));
      wa_data = $urandom; wb_data = $urandom;
      wa_be = 4'($urandom); wb_be = 4'($urandom);
      r0 = ($urandom_range(0, 1) == 0) ? wa_addr : 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 1) == 0) ? wb_addr : 5'($urandom);
      rd_addr = {r1, r0};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
